cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for a small accumulator CPU: fetch/exec/mem
// stepping with single-step support, memory timeout and a retired counter.
module cpu_sequencer #(
  parameter int OP_W     = 3,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [OP_W-1:0]  op,
  input  logic             z_flag,
  input  logic             mem_ack,
  input  logic             run,
  input  logic             step,
  output logic             load_IR,
  output logic             INC_PC,
  output logic             load_PC,
  output logic             load_REG,
  output logic             ALU_REG,
  output logic             ALU_add,
  output logic             ALU_sub,
  output logic             WE,
  output logic             IMM,
  output logic             mem_req,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_STORE = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_LDI   = 3'd4;
  localparam logic [2:0] OP_JMP   = 3'd5;
  localparam logic [2:0] OP_BZ    = 3'd6;
  localparam logic [2:0] OP_HALT  = 3'd7;

  localparam logic [7:0]       WAIT_LAST = 8'(WAIT_MAX - 1);
  localparam logic [CNT_W-1:0] RET_MAX   = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  state_t           state_r;
  logic             step_q_r;
  logic [7:0]       wait_cnt_r;
  logic [CNT_W-1:0] retired_r;
  logic             err_r;

  logic             step_rise_s;
  logic             done_s;
  logic             timeout_s;

  assign step_rise_s = step & ~step_q_r;
  assign timeout_s   = (state_r == ST_MEM) && !mem_ack && (wait_cnt_r == WAIT_LAST);

  // Instruction completion: non-memory ops finish in EXEC, memory ops on ack.
  always_comb begin
    done_s = 1'b0;
    case (state_r)
      ST_EXEC: begin
        if (op[2]) begin
          done_s = 1'b1;
        end else begin
          done_s = 1'b0;
        end
      end
      ST_MEM: done_s = mem_ack;
      default: done_s = 1'b0;
    endcase
  end

  // Sequencer state, step edge detector, wait counter, retired count, sticky error.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      step_q_r   <= 1'b0;
      wait_cnt_r <= 8'd0;
      retired_r  <= '0;
      err_r      <= 1'b0;
    end else begin
      step_q_r <= step;
      if (done_s && (retired_r != RET_MAX)) begin
        retired_r <= retired_r + CNT_W'(1);
      end
      case (state_r)
        ST_IDLE: begin
          if (run || step_rise_s) begin
            state_r <= ST_FETCH;
          end
        end
        ST_FETCH: state_r <= ST_EXEC;
        ST_EXEC: begin
          case (op)
            OP_LOAD, OP_STORE, OP_ADD, OP_SUB: begin
              state_r    <= ST_MEM;
              wait_cnt_r <= 8'd0;
            end
            OP_HALT: state_r <= ST_HALTED;
            default: state_r <= run ? ST_FETCH : ST_IDLE;
          endcase
        end
        ST_MEM: begin
          // An ack in the timeout cycle still completes the access.
          if (mem_ack) begin
            state_r <= run ? ST_FETCH : ST_IDLE;
          end else if (timeout_s) begin
            state_r <= ST_HALTED;
            err_r   <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        ST_HALTED: state_r <= ST_HALTED;
        default:   state_r <= ST_IDLE;
      endcase
    end
  end

  // Datapath pulses decoded from the current state; reset forces everything low.
  always_comb begin
    load_IR  = 1'b0;
    INC_PC   = 1'b0;
    load_PC  = 1'b0;
    load_REG = 1'b0;
    ALU_REG  = 1'b0;
    ALU_add  = 1'b0;
    ALU_sub  = 1'b0;
    WE       = 1'b0;
    IMM      = 1'b0;
    mem_req  = 1'b0;
    busy     = 1'b0;
    halted   = 1'b0;
    err      = 1'b0;
    retired  = '0;
    if (reset) begin
      retired = '0;
    end else begin
      err     = err_r;
      retired = retired_r;
      case (state_r)
        ST_FETCH: begin
          busy    = 1'b1;
          load_IR = 1'b1;
          INC_PC  = 1'b1;
        end
        ST_EXEC: begin
          busy = 1'b1;
          case (op)
            OP_LDI: begin
              IMM      = 1'b1;
              ALU_REG  = 1'b1;
              load_REG = 1'b1;
            end
            OP_JMP:  load_PC = 1'b1;
            OP_BZ:   load_PC = z_flag;
            default: load_PC = 1'b0;
          endcase
        end
        ST_MEM: begin
          busy    = 1'b1;
          mem_req = 1'b1;
          if (mem_ack) begin
            case (op)
              OP_LOAD: begin
                ALU_REG  = 1'b1;
                load_REG = 1'b1;
              end
              OP_ADD: begin
                ALU_add  = 1'b1;
                load_REG = 1'b1;
              end
              OP_SUB: begin
                ALU_sub  = 1'b1;
                load_REG = 1'b1;
              end
              OP_STORE: WE = 1'b1;
              default:  WE = 1'b0;
            endcase
          end else begin
            WE = 1'b0;
          end
        end
        ST_HALTED: halted = 1'b1;
        default:   busy   = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer (WAIT_MAX=4, CNT_W=4): every cycle's
// control/status vector is compared against hand-derived values.
module tb_cpu_sequencer;

  localparam logic [12:0] B_IR   = 13'h1000;
  localparam logic [12:0] B_INC  = 13'h0800;
  localparam logic [12:0] B_LPC  = 13'h0400;
  localparam logic [12:0] B_LREG = 13'h0200;
  localparam logic [12:0] B_AREG = 13'h0100;
  localparam logic [12:0] B_ADD  = 13'h0080;
  localparam logic [12:0] B_SUB  = 13'h0040;
  localparam logic [12:0] B_WE   = 13'h0020;
  localparam logic [12:0] B_IMM  = 13'h0010;
  localparam logic [12:0] B_MREQ = 13'h0008;
  localparam logic [12:0] B_BUSY = 13'h0004;
  localparam logic [12:0] B_HALT = 13'h0002;
  localparam logic [12:0] B_ERR  = 13'h0001;

  localparam logic [12:0] E_IDLE  = 13'h0000;
  localparam logic [12:0] E_FETCH = B_IR | B_INC | B_BUSY;
  localparam logic [12:0] E_EXEC  = B_BUSY;
  localparam logic [12:0] E_LDI   = B_IMM | B_AREG | B_LREG | B_BUSY;
  localparam logic [12:0] E_JMP   = B_LPC | B_BUSY;
  localparam logic [12:0] E_MEMW  = B_MREQ | B_BUSY;

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_STORE = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_LDI   = 3'd4;
  localparam logic [2:0] OP_JMP   = 3'd5;
  localparam logic [2:0] OP_BZ    = 3'd6;
  localparam logic [2:0] OP_HALT  = 3'd7;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] op;
  logic       z_flag, mem_ack, run, step;
  logic       load_IR, INC_PC, load_PC, load_REG, ALU_REG, ALU_add, ALU_sub, WE, IMM;
  logic       mem_req, busy, halted, err;
  logic [3:0] retired;
  logic [12:0] ctl_s;

  int checks = 0;
  int errors = 0;

  cpu_sequencer #(.OP_W(3), .WAIT_MAX(4), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .op(op), .z_flag(z_flag), .mem_ack(mem_ack),
    .run(run), .step(step), .load_IR(load_IR), .INC_PC(INC_PC), .load_PC(load_PC),
    .load_REG(load_REG), .ALU_REG(ALU_REG), .ALU_add(ALU_add), .ALU_sub(ALU_sub),
    .WE(WE), .IMM(IMM), .mem_req(mem_req), .busy(busy), .halted(halted),
    .err(err), .retired(retired)
  );

  always #5 clock = ~clock;

  assign ctl_s = {load_IR, INC_PC, load_PC, load_REG, ALU_REG, ALU_add, ALU_sub,
                  WE, IMM, mem_req, busy, halted, err};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check the current cycle's outputs (inputs already applied), then advance one clock.
  task automatic cyc(input string tag, input logic [12:0] exp);
    #1;
    check(tag, 32'(ctl_s), 32'(exp));
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc("in_reset", E_IDLE);
    check("ret_in_reset", 32'(retired), 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; op = OP_LDI; z_flag = 1'b0; mem_ack = 1'b0; run = 1'b0; step = 1'b0;
    @(posedge clock);
    #1;

    // Free-run program: LDI, ADD (ack on third MEM cycle), JMP.
    do_reset();
    run = 1'b1;
    cyc("p1_idle", E_IDLE);
    cyc("p1_fetch0", E_FETCH);
    op = OP_LDI;  cyc("p1_ldi", E_LDI);
    cyc("p1_fetch1", E_FETCH);
    op = OP_ADD;  cyc("p1_add_exec", E_EXEC);
    cyc("p1_mem0", E_MEMW);
    cyc("p1_mem1", E_MEMW);
    mem_ack = 1'b1; cyc("p1_mem2_ack", E_MEMW | B_ADD | B_LREG);
    mem_ack = 1'b0; cyc("p1_fetch2", E_FETCH);
    op = OP_JMP; run = 1'b0; cyc("p1_jmp", E_JMP);
    cyc("p1_back_idle", E_IDLE);
    check("p1_retired", 32'(retired), 32'd3);

    // Single step: step held high for 5 cycles runs exactly one instruction.
    do_reset();
    step = 1'b1; op = OP_LDI;
    cyc("s_idle_rise", E_IDLE);
    cyc("s_fetch", E_FETCH);
    cyc("s_ldi", E_LDI);
    cyc("s_idle_hold0", E_IDLE);
    cyc("s_idle_hold1", E_IDLE);
    check("s_retired1", 32'(retired), 32'd1);
    step = 1'b0; cyc("s_idle_low", E_IDLE);
    step = 1'b1; cyc("s2_idle_rise", E_IDLE);
    step = 1'b0; cyc("s2_fetch", E_FETCH);
    step = 1'b1; cyc("s2_ldi_edge_dropped", E_LDI);
    cyc("s2_idle_no_queue", E_IDLE);
    cyc("s2_still_idle", E_IDLE);
    check("s_retired2", 32'(retired), 32'd2);
    step = 1'b0;

    // BZ not taken then taken; mem_ack high outside MEM must be ignored.
    do_reset();
    run = 1'b1; op = OP_BZ; mem_ack = 1'b1;
    cyc("bz_idle", E_IDLE);
    cyc("bz_fetch0", E_FETCH);
    z_flag = 1'b0; cyc("bz_z0", E_EXEC);
    cyc("bz_fetch1", E_FETCH);
    z_flag = 1'b1; run = 1'b0; cyc("bz_z1", E_JMP);
    cyc("bz_idle_end", E_IDLE);
    check("bz_retired", 32'(retired), 32'd2);
    mem_ack = 1'b0; z_flag = 1'b0;

    // STORE with ack in the last allowed MEM cycle completes normally.
    run = 1'b1; op = OP_STORE;
    cyc("st_idle", E_IDLE);
    cyc("st_fetch", E_FETCH);
    cyc("st_exec", E_EXEC);
    cyc("st_mem0", E_MEMW);
    cyc("st_mem1", E_MEMW);
    cyc("st_mem2", E_MEMW);
    mem_ack = 1'b1; run = 1'b0; cyc("st_mem3_ack", E_MEMW | B_WE);
    mem_ack = 1'b0; cyc("st_idle_end", E_IDLE);
    check("st_retired", 32'(retired), 32'd3);

    // STORE with no ack times out after four MEM cycles.
    run = 1'b1;
    cyc("to_idle", E_IDLE);
    cyc("to_fetch", E_FETCH);
    cyc("to_exec", E_EXEC);
    cyc("to_mem0", E_MEMW);
    cyc("to_mem1", E_MEMW);
    cyc("to_mem2", E_MEMW);
    cyc("to_mem3", E_MEMW);
    cyc("to_halted", B_HALT | B_ERR);
    mem_ack = 1'b1; step = 1'b1; cyc("to_absorb0", B_HALT | B_ERR);
    step = 1'b0; cyc("to_absorb1", B_HALT | B_ERR);
    check("to_retired", 32'(retired), 32'd3);
    mem_ack = 1'b0; run = 1'b0;
    do_reset();
    cyc("to_cleared", E_IDLE);

    // HALT counts as retired and parks without error.
    run = 1'b1; op = OP_HALT;
    cyc("h_idle", E_IDLE);
    cyc("h_fetch", E_FETCH);
    cyc("h_exec", E_EXEC);
    cyc("h_halted", B_HALT);
    cyc("h_halted2", B_HALT);
    check("h_retired", 32'(retired), 32'd1);

    // Reset in the same cycle as a LOAD ack suppresses the register load.
    do_reset();
    op = OP_LOAD;
    cyc("rl_idle", E_IDLE);
    cyc("rl_fetch", E_FETCH);
    cyc("rl_exec", E_EXEC);
    cyc("rl_mem0", E_MEMW);
    mem_ack = 1'b1; reset = 1'b1; cyc("rl_reset_ack", E_IDLE);
    reset = 1'b0; mem_ack = 1'b0; run = 1'b0;
    cyc("rl_after", E_IDLE);
    check("rl_retired", 32'(retired), 32'd0);

    // 20 LDIs with a 4-bit counter saturate retired at 15.
    run = 1'b1; op = OP_LDI;
    cyc("sat_idle", E_IDLE);
    for (int i = 0; i < 20; i++) begin
      cyc("sat_fetch", E_FETCH);
      if (i == 19) run = 1'b0;
      cyc("sat_ldi", E_LDI);
      if (i == 14) check("sat_at15", 32'(retired), 32'd15);
    end
    cyc("sat_idle_end", E_IDLE);
    check("sat_retired", 32'(retired), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
